// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bit-serial address/data bus. Both the master and
// the slave import this package so that frame geometry, write_en polarity and
// the FSM state encoding stay consistent on both ends of the link.
//
// Contents:
//   ADDR_W, DATA_W, MEM_ADDR_W, TIMEOUT : default frame/memory geometry
//   CNT_W, ST_W                         : debug counter and state widths
//   WRITE                               : write_en level that marks a write frame
//   ST_*                                : FSM state encoding (debug visible)
//   data_slot()                         : is this bit position a data bit?
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 8;
  localparam int MEM_ADDR_W = 11;
  localparam int TIMEOUT    = 1023;

  localparam int CNT_W = 5;
  localparam int ST_W  = 3;

  localparam logic WRITE = 1'b1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RX_ADDR   = 3'd1;
  localparam logic [2:0] ST_RX_PAUSE  = 3'd2;
  localparam logic [2:0] ST_WR_COMMIT = 3'd3;
  localparam logic [2:0] ST_RD_FETCH  = 3'd4;
  localparam logic [2:0] ST_RD_VALID  = 3'd5;
  localparam logic [2:0] ST_TX_DATA   = 3'd6;

  // Data bits ride alongside the last DATA_W address bits of a write frame:
  // the bit being received at count cnt is a data bit when cnt lies in
  // [addr_w - data_w, addr_w - 1].
  function automatic logic data_slot(input logic [CNT_W-1:0] cnt,
                                     input int addr_w,
                                     input int data_w);
    int c;
    c = int'(cnt);
    return (c >= (addr_w - data_w)) && (c < addr_w);
  endfunction

endpackage

// File: rtl/slave_bram.sv
// -----------------------------------------------------------------------------
// slave_bram
// Single-port byte RAM backing the bus slave. Depth is 2**AW entries.
// Writes are synchronous; reads return the addressed byte one cycle after
// rd_en through an output register. Contents are never cleared by reset.
//
// Ports:
//   clock  : system clock
//   wr_en  : write strobe (wdata -> mem[addr] at the clock edge)
//   rd_en  : read strobe (mem[addr] -> rdata at the clock edge)
//   addr   : word index
//   wdata  : write byte
//   rdata  : registered read byte, held between reads
// -----------------------------------------------------------------------------
module slave_bram #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];
  logic [DW-1:0] rdata_r;

  // Write port: the array itself carries no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read port: output register holds the last fetched byte until the next read.
  always_ff @(posedge clock) begin
    if (rd_en) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/bus_slave.sv
// -----------------------------------------------------------------------------
// bus_slave
// Slave end of the bit-serial bus. Receives an ADDR_W-bit address MSB first;
// write frames also carry DATA_W data bits alongside the final DATA_W address
// bits and are committed to a local byte RAM. Read frames fetch the byte,
// pulse slave_valid for one cycle and then shift the byte out MSB first.
// If the master drops valid_s mid-address the slave waits in RX_PAUSE and
// aborts the frame after TIMEOUT consecutive idle cycles with no write.
//
// Ports:
//   clock       : system clock, all logic on posedge
//   reset       : synchronous active-high reset (memory is not cleared)
//   valid_s     : master frame-valid, high while bits are shifted
//   write_en    : frame direction, sampled on the first valid_s-high cycle
//   addr_rx     : serial address bit, MSB first
//   data_rx     : serial write-data bit, MSB first
//   slave_ready : high when idle and able to accept a frame
//   slave_valid : one-cycle pulse, read data follows on data_tx
//   data_tx     : serial read-data bit, MSB first
//   state       : current FSM state (debug)
//   bit_cnt     : received/transmitted bit count (debug)
// -----------------------------------------------------------------------------
module bus_slave #(
  parameter int ADDR_W     = bus_pkg::ADDR_W,
  parameter int MEM_ADDR_W = bus_pkg::MEM_ADDR_W,
  parameter int DATA_W     = bus_pkg::DATA_W,
  parameter int TIMEOUT    = bus_pkg::TIMEOUT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid_s,
  input  logic       write_en,
  input  logic       addr_rx,
  input  logic       data_rx,
  output logic       slave_ready,
  output logic       slave_valid,
  output logic       data_tx,
  output logic [2:0] state,
  output logic [4:0] bit_cnt
);

  import bus_pkg::*;

  localparam int TO_W = $clog2(TIMEOUT + 1);

  // Registered state
  logic [ST_W-1:0]       state_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic [MEM_ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0]     data_r;
  logic                  we_r;
  logic [TO_W-1:0]       timeout_r;
  logic [DATA_W-1:0]     tx_sh_r;
  logic                  ready_r;
  logic                  valid_r;
  logic                  tx_r;

  // Next-state values
  logic [ST_W-1:0]       state_nxt_s;
  logic [CNT_W-1:0]      bit_cnt_nxt_s;
  logic [MEM_ADDR_W-1:0] addr_nxt_s;
  logic [DATA_W-1:0]     data_nxt_s;
  logic                  we_nxt_s;
  logic [TO_W-1:0]       timeout_nxt_s;
  logic [DATA_W-1:0]     tx_sh_nxt_s;
  logic                  tx_nxt_s;

  // Memory interface
  logic                  mem_wr_s;
  logic                  mem_rd_s;
  logic [DATA_W-1:0]     mem_rdata_s;

  // Only the low MEM_ADDR_W bits are kept: upper address bits shift out of
  // the top of addr_r, which gives the intended aliasing for free.

  // Next-state and datapath decode for the frame FSM.
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    addr_nxt_s    = addr_r;
    data_nxt_s    = data_r;
    we_nxt_s      = we_r;
    timeout_nxt_s = {TO_W{1'b0}};
    tx_sh_nxt_s   = tx_sh_r;
    tx_nxt_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (valid_s) begin
          we_nxt_s      = write_en;
          addr_nxt_s    = {{(MEM_ADDR_W-1){1'b0}}, addr_rx};
          data_nxt_s    = {DATA_W{1'b0}};
          bit_cnt_nxt_s = CNT_W'(1);
          state_nxt_s   = ST_RX_ADDR;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end

      // A valid cycle in RX_PAUSE consumes its bit exactly like RX_ADDR,
      // so the resume and the normal receive share one path.
      ST_RX_ADDR, ST_RX_PAUSE: begin
        if (valid_s) begin
          addr_nxt_s    = {addr_r[MEM_ADDR_W-2:0], addr_rx};
          if ((we_r == WRITE) && data_slot(bit_cnt_r, ADDR_W, DATA_W)) begin
            data_nxt_s  = {data_r[DATA_W-2:0], data_rx};
          end else begin
            data_nxt_s  = data_r;
          end
          bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
          if (bit_cnt_r == CNT_W'(ADDR_W - 1)) begin
            state_nxt_s = (we_r == WRITE) ? ST_WR_COMMIT : ST_RD_FETCH;
          end else begin
            state_nxt_s = ST_RX_ADDR;
          end
        end else if (state_r == ST_RX_ADDR) begin
          state_nxt_s   = ST_RX_PAUSE;
        end else if (timeout_r == TO_W'(TIMEOUT - 1)) begin
          // This idle cycle brings the count to TIMEOUT: drop the frame.
          state_nxt_s   = ST_IDLE;
          bit_cnt_nxt_s = {CNT_W{1'b0}};
          addr_nxt_s    = {MEM_ADDR_W{1'b0}};
          data_nxt_s    = {DATA_W{1'b0}};
        end else begin
          timeout_nxt_s = timeout_r + TO_W'(1);
        end
      end

      ST_WR_COMMIT: begin
        state_nxt_s   = ST_IDLE;
        bit_cnt_nxt_s = {CNT_W{1'b0}};
      end

      ST_RD_FETCH: begin
        state_nxt_s   = ST_RD_VALID;
        bit_cnt_nxt_s = {CNT_W{1'b0}};
      end

      // RAM output is valid here; bit 7 goes out on the next cycle.
      ST_RD_VALID: begin
        tx_nxt_s      = mem_rdata_s[DATA_W-1];
        tx_sh_nxt_s   = {mem_rdata_s[DATA_W-2:0], 1'b0};
        bit_cnt_nxt_s = CNT_W'(1);
        state_nxt_s   = ST_TX_DATA;
      end

      ST_TX_DATA: begin
        if (bit_cnt_r == CNT_W'(DATA_W)) begin
          state_nxt_s   = ST_IDLE;
          bit_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
          tx_nxt_s      = tx_sh_r[DATA_W-1];
          tx_sh_nxt_s   = {tx_sh_r[DATA_W-2:0], 1'b0};
          bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
        end
      end

      default: begin
        state_nxt_s   = ST_IDLE;
        bit_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, datapath and registered outputs; reset overrides every other event.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= {CNT_W{1'b0}};
      addr_r    <= {MEM_ADDR_W{1'b0}};
      data_r    <= {DATA_W{1'b0}};
      we_r      <= 1'b0;
      timeout_r <= {TO_W{1'b0}};
      tx_sh_r   <= {DATA_W{1'b0}};
      ready_r   <= 1'b1;
      valid_r   <= 1'b0;
      tx_r      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      addr_r    <= addr_nxt_s;
      data_r    <= data_nxt_s;
      we_r      <= we_nxt_s;
      timeout_r <= timeout_nxt_s;
      tx_sh_r   <= tx_sh_nxt_s;
      ready_r   <= (state_nxt_s == ST_IDLE);
      valid_r   <= (state_nxt_s == ST_RD_VALID);
      tx_r      <= tx_nxt_s;
    end
  end

  // A reset landing on the commit cycle must not write memory.
  assign mem_wr_s = (state_r == ST_WR_COMMIT) && !reset;
  assign mem_rd_s = (state_r == ST_RD_FETCH);

  slave_bram #(
    .AW (MEM_ADDR_W),
    .DW (DATA_W)
  ) u_bram (
    .clock (clock),
    .wr_en (mem_wr_s),
    .rd_en (mem_rd_s),
    .addr  (addr_r),
    .wdata (data_r),
    .rdata (mem_rdata_s)
  );

  assign slave_ready = ready_r;
  assign slave_valid = valid_r;
  assign data_tx     = tx_r;
  assign state       = state_r;
  assign bit_cnt     = bit_cnt_r;

endmodule

// File: tb/tb_bus_slave.sv
// -----------------------------------------------------------------------------
// tb_bus_slave
// Self-checking bench for bus_slave. Frames are driven bit by bit; the
// reference model is a byte array indexed by the low 11 address bits, and
// frame timing expectations come from the protocol rules (write busy for
// 15 cycles, read busy for 24, slave_valid two cycles after address bit 0,
// then 8 serial bits MSB first), each stretched by any pause length.
// -----------------------------------------------------------------------------
module tb_bus_slave;

  localparam int TIMEOUT = 1023;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       valid_s = 1'b0;
  logic       write_en = 1'b0;
  logic       addr_rx = 1'b0;
  logic       data_rx = 1'b0;
  logic       slave_ready;
  logic       slave_valid;
  logic       data_tx;
  logic [2:0] state;
  logic [4:0] bit_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] model_mem [int];
  int         written_q [$];

  bus_slave #(
    .ADDR_W     (14),
    .MEM_ADDR_W (11),
    .DATA_W     (8),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .valid_s     (valid_s),
    .write_en    (write_en),
    .addr_rx     (addr_rx),
    .data_rx     (data_rx),
    .slave_ready (slave_ready),
    .slave_valid (slave_valid),
    .data_tx     (data_tx),
    .state       (state),
    .bit_cnt     (bit_cnt)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drive_noise(input logic v);
    valid_s  = v;
    write_en = 1'($urandom);
    addr_rx  = 1'($urandom);
    data_rx  = 1'($urandom);
  endtask

  // Drive one frame and check it. pause_at/pause_len insert valid_s-low
  // cycles before bit index pause_at; reset_at asserts reset on that bit.
  task automatic do_frame(input logic [13:0] a, input logic [7:0] d, input bit wr,
                          input int pause_at, input int pause_len, input int reset_at);
    int         c0;
    bit         aborted;
    int         busy;
    int         valid_seen;
    int         valid_pos;
    int         tx_at_valid;
    logic [7:0] rx_byte;
    int         idx;
    int         plen;

    idx     = int'(a[10:0]);
    aborted = 1'b0;
    plen    = 0;
    check_val("ready_before_frame", int'(slave_ready), 1);
    c0 = cyc;
    for (int k = 0; k < 14; k++) begin
      if (!aborted && k == pause_at && pause_len > 0) begin
        plen = pause_len;
        for (int p = 0; p < pause_len; p++) begin
          drive_noise(1'b0);
          tick();
        end
        if (pause_len > TIMEOUT) begin
          aborted = 1'b1;
          check_val("abort_ready", int'(slave_ready), 1);
          check_val("abort_state", int'(state), int'(bus_pkg::ST_IDLE));
          check_val("abort_bit_cnt", int'(bit_cnt), 0);
        end else begin
          check_val("pause_bit_cnt", int'(bit_cnt), k);
          check_val("pause_ready", int'(slave_ready), 0);
        end
      end
      if (!aborted) begin
        if (k == reset_at) reset = 1'b1;
        valid_s  = 1'b1;
        write_en = (k == 0) ? wr : 1'($urandom);
        addr_rx  = a[13-k];
        data_rx  = (wr && k >= 6) ? d[13-k] : 1'($urandom);
        tick();
        if (k == reset_at) begin
          reset   = 1'b0;
          valid_s = 1'b0;
          aborted = 1'b1;
          check_val("rst_state", int'(state), int'(bus_pkg::ST_IDLE));
          check_val("rst_ready", int'(slave_ready), 1);
          check_val("rst_valid", int'(slave_valid), 0);
          check_val("rst_data_tx", int'(data_tx), 0);
          check_val("rst_bit_cnt", int'(bit_cnt), 0);
        end
      end
    end
    valid_s = 1'b0;
    if (aborted) return;

    busy        = -1;
    valid_seen  = 0;
    valid_pos   = -1;
    tx_at_valid = -1;
    rx_byte     = 8'h00;
    // post 0 is the cycle after address bit 0; valid_s is don't-care here.
    for (int post = 0; post < 40; post++) begin
      if (slave_ready) begin
        busy = cyc - c0;
        break;
      end
      if (slave_valid) begin
        valid_seen++;
        valid_pos   = post;
        tx_at_valid = int'(data_tx);
      end
      if (post >= 2 && post <= 9) rx_byte = {rx_byte[6:0], data_tx};
      drive_noise(1'($urandom));
      tick();
    end
    valid_s = 1'b0;

    if (wr) begin
      check_val("wr_busy_cycles", busy, 15 + plen);
      check_val("wr_no_valid", valid_seen, 0);
      if (!model_mem.exists(idx)) written_q.push_back(idx);
      model_mem[idx] = d;
    end else begin
      check_val("rd_busy_cycles", busy, 24 + plen);
      check_val("rd_valid_count", valid_seen, 1);
      check_val("rd_valid_pos", valid_pos, 1);
      check_val("rd_tx_zero_at_valid", tx_at_valid, 0);
      if (model_mem.exists(idx)) begin
        check_val("rd_data", int'(rx_byte), int'(model_mem[idx]));
      end
    end
  endtask

  initial begin
    logic [13:0] a;
    logic [7:0]  d;
    bit          wr;
    int          pa;
    int          pl;

    reset = 1'b1;
    repeat (3) tick();
    check_val("reset_state", int'(state), int'(bus_pkg::ST_IDLE));
    check_val("reset_ready", int'(slave_ready), 1);
    check_val("reset_valid", int'(slave_valid), 0);
    check_val("reset_data_tx", int'(data_tx), 0);
    check_val("reset_bit_cnt", int'(bit_cnt), 0);
    reset = 1'b0;
    tick();

    // Basic write then read-back of 0x0A5.
    do_frame(14'h00A5, 8'h3C, 1'b1, -1, 0, -1);
    do_frame(14'h00A5, 8'h00, 1'b0, -1, 0, -1);

    // Short pause mid-address, then resume.
    do_frame(14'h0123, 8'hFF, 1'b1, 3, 5, -1);
    do_frame(14'h0123, 8'h00, 1'b0, -1, 0, -1);

    // Pause of TIMEOUT+1 cycles aborts; memory keeps 0x3C.
    do_frame(14'h00A5, 8'h77, 1'b1, 3, TIMEOUT + 1, -1);
    do_frame(14'h00A5, 8'h00, 1'b0, -1, 0, -1);

    // Pause of exactly TIMEOUT cycles before the last bit still completes.
    do_frame(14'h2222, 8'hC3, 1'b1, 13, TIMEOUT, -1);
    do_frame(14'h0222, 8'h00, 1'b0, -1, 0, -1);

    // Reset on address bit 9 of a write; the next read starts immediately.
    do_frame(14'h00A5, 8'h99, 1'b1, -1, 0, 4);
    do_frame(14'h00A5, 8'h00, 1'b0, -1, 0, -1);

    // Upper address bits alias.
    do_frame(14'h3801, 8'h5A, 1'b1, -1, 0, -1);
    do_frame(14'h0001, 8'h00, 1'b0, -1, 0, -1);

    // Randomized frames, many back-to-back from the first IDLE cycle.
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom);
      pa = int'($urandom_range(1, 13));
      pl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
      d  = 8'($urandom);
      if (wr) begin
        a = 14'($urandom);
      end else begin
        a = {3'($urandom), 11'(written_q[$urandom_range(0, written_q.size() - 1)])};
      end
      do_frame(a, d, wr, pa, pl, -1);
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          drive_noise(1'b0);
          tick();
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_slave.md
Name: bus_slave

Overview:
- Serial bus responder: the slave end of the master's bit-serial address/data protocol.
- Deserialises a 14-bit address, MSB first. For writes it also deserialises 8 data bits and commits them to a local byte memory.
- For reads it fetches a byte, pulses slave_valid, then serialises the byte back MSB first.
- Sits behind the bus arbiter/decoder; it sees only frames routed to it.

Parameters:
- ADDR_W, 14, serial address width received per frame.
- MEM_ADDR_W, 11, local memory index width (low bits of the address; upper bits ignored).
- DATA_W, 8, data byte width.
- TIMEOUT, 1023, max consecutive valid_s-low cycles tolerated mid-frame before abort.

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- valid_s  in  1  master frame-valid; high while the master shifts bits
- write_en  in  1  1=write frame, 0=read frame; sampled on the first valid_s-high cycle
- addr_rx  in  1  serial address bit, MSB first
- data_rx  in  1  serial write-data bit, MSB first
- slave_ready  out  1  1=idle and able to accept a frame
- slave_valid  out  1  one-cycle pulse: read data follows
- data_tx  out  1  serial read-data bit, MSB first
- state  out  3  current FSM state (debug)
- bit_cnt  out  5  received/transmitted bit count (debug)

Behaviour:
- Reset: state=IDLE, slave_ready=1, slave_valid=0, data_tx=0, bit_cnt=0. Address, data and timeout registers are cleared. Memory contents are not cleared. Reset mid-frame aborts with no memory write.
- States: IDLE, RX_ADDR, RX_PAUSE, WR_COMMIT, RD_FETCH, RD_VALID, TX_DATA.
- IDLE:
  - On valid_s=1: latch write_en, shift addr_rx in as address bit 13, set bit_cnt=1, clear slave_ready, go to RX_ADDR.
- RX_ADDR, each cycle with valid_s=1:
  - Shift addr_rx into the address register and increment bit_cnt.
  - Write frames only: when bit_cnt (before increment) is 6..13, also shift data_rx into the data register. Data bit 7 arrives with address bit 7; data bit 0 arrives with address bit 0.
- RX_ADDR, valid_s=0 before 14 bits: go to RX_PAUSE with bit_cnt held.
- RX_PAUSE (bus lost, master re-arbitrating):
  - Increment the timeout counter each cycle.
  - valid_s=1: resume RX_ADDR, consuming that cycle's bit at the held bit_cnt, and clear the timeout counter.
  - Counter reaches TIMEOUT: abort to IDLE with no memory write and slave_ready=1.
- RX_ADDR, after bit_cnt=14: go to WR_COMMIT if the latched write_en=1, else RD_FETCH. valid_s is ignored from then on.
- WR_COMMIT (1 cycle): write mem[addr[MEM_ADDR_W-1:0]]=data, then IDLE. slave_ready returns to 1 the cycle after WR_COMMIT.
- RD_FETCH (1 cycle): issue the synchronous memory read.
- RD_VALID (1 cycle): slave_valid=1, load the read byte into the tx shift register, data_tx=0.
- TX_DATA (8 cycles): data_tx drives bit 7 in the first cycle and bit 0 in the eighth, then go to IDLE.
- Read latency: slave_valid is high exactly 2 cycles after the cycle carrying address bit 0; data_tx bit 7 follows on the next cycle.
- Frame boundaries:
  - valid_s held high after a frame completes does not start a new frame until the FSM is back in IDLE.
  - A new frame may start in the first IDLE cycle.
- Address handling: upper ADDR_W-MEM_ADDR_W bits are ignored (aliasing is intentional).
- Simultaneous events: reset has priority over everything; timeout expiry and valid_s=1 in the same cycle resolves as resume.

Decomposition:
- Shared package bus_pkg: ADDR_W, DATA_W, the state encoding constants, and the write_en polarity constant (WRITE=1). The master adopts the same package.
- One sub-module, slave_bram: single-port byte RAM, depth 2**MEM_ADDR_W, synchronous write, 1-cycle registered read.

Test Plan:
- Write 0x0A5=0x3C: 14 address bits with data bits on cycles 7..14 -> slave_ready low for 15 cycles; a later read of 0x0A5 returns 0x3C.
- Read 0x0A5 after that write -> slave_valid pulses 2 cycles after the last address bit; data_tx serialises 0,0,1,1,1,1,0,0 on the next 8 cycles; slave_ready=1 after.
- Write 0x123=0xFF with valid_s dropped for 5 cycles after bit 2, then resumed -> memory 0x123=0xFF, no abort.
- Write frame with valid_s dropped for TIMEOUT+1 cycles after bit 2 -> abort to IDLE, slave_ready=1, memory unchanged.
- Reset asserted at address bit 9 of a write -> outputs return to reset values next cycle, memory unchanged; an immediate new read frame succeeds.
- Aliasing: write 0x3801=0x5A, read 0x0001 -> returns 0x5A.
